dmem_dbg: RTL and testbench
===========================

Name: dmem_dbg

Overview:
- Parametrised successor to the single-cycle CPU's 16-bit data memory.
- Generalised in width and depth.
- Adds a hardware clear sequence after reset, so contents are deterministic without bench-side forcing.
- Adds a debug request/acknowledge port so a host or bench can load and peek words while the CPU runs; sits between the CPU datapath and the board-level debug logic.

Parameters:
- DATA_W, 16, word width in bits.
- DEPTH, 256, number of words; need not be a power of two.
- ADDR_W, $clog2(DEPTH), address width (derived, not overridden).

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RST  in  1  asynchronous, active-low reset.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_we  in  1  CPU write enable; sampled on CLK rise.
- cpu_rdata  out  DATA_W  combinational read of mem[cpu_addr].
- ready  out  1  high once the clear sequence has completed.
- dbg_req  in  1  debug request; held until dbg_ack.
- dbg_we  in  1  1 = debug write, 0 = debug read; qualified by dbg_req.
- dbg_addr  in  ADDR_W  debug word address.
- dbg_wdata  in  DATA_W  debug write data.
- dbg_ack  out  1  one-cycle completion pulse.
- dbg_rdata  out  DATA_W  registered debug read data; valid while dbg_ack = 1, then held.

Behaviour:
- Reset (RST low, asynchronous): state = CLEAR, clr_cnt = 0, ready = 0, dbg_ack = 0, dbg_rdata = 0.
- Memory array is not reset directly; the clear sequence zeroes it.
- States: CLEAR, RUN, ACK.
- CLEAR:
  - Each cycle writes 0 to mem[clr_cnt] and increments clr_cnt.
  - After writing DEPTH-1, goes to RUN; ready rises the same edge. The clear takes exactly DEPTH cycles after RST deasserts.
  - cpu_rdata = 0, CPU writes are dropped, and debug requests wait.
- RUN:
  - cpu_we = 1 writes cpu_wdata to mem[cpu_addr] at the edge.
  - If dbg_req = 1 and cpu_we = 0: the debug access executes at that edge. A write updates mem; a read loads dbg_rdata. The state then goes to ACK.
  - If dbg_req = 1 and cpu_we = 1: the CPU wins and the debug access waits. There is no starvation guarantee.
- ACK:
  - dbg_ack = 1 for exactly one cycle; no debug access is started.
  - CPU writes proceed normally; the state returns to RUN.
  - If dbg_req is still high in RUN afterwards, it is a new request.
- Read-after-write: cpu_rdata reflects a write in the cycle after the edge. A debug read of an address written by the CPU in the same cycle cannot occur, because of the arbitration above.
- Out-of-range addresses (addr >= DEPTH): reads return 0; writes are dropped silently. A debug out-of-range access still acks.
- RST asserted mid-clear or mid-ACK: everything aborts immediately; the clear restarts from address 0 after release.

Optional Feature:
- DMEM_LOCK_EN defined:
  - A per-word lock bit array is added, plus input dbg_lock (1 bit).
  - A debug write with dbg_lock = 1 sets the lock bit of that word; a debug write with dbg_lock = 0 clears it.
  - CPU writes to a locked word are ignored; debug writes always succeed.
  - The clear sequence clears all lock bits.
- DMEM_LOCK_EN undefined: no dbg_lock port and no lock array; CPU writes are never blocked.

Decomposition:
- Package dmem_pkg holds:
  - typedef enum logic [1:0] {CLEAR, RUN, ACK} dmem_state_t;
  - localparam defaults DMEM_DATA_W = 16 and DMEM_DEPTH = 256.
- One sub-module, dmem_array: storage with one write port (muxed among clear, CPU and debug) and two combinational read ports. The FSM and arbitration stay in dmem_dbg.

Test Plan:
- Clear: DEPTH = 8; release RST.
  - ready rises after exactly 8 cycles.
  - cpu_rdata reads 0x0000 at all 8 addresses.
- CPU write/read: write 0xA5A5 to addr 3 → cpu_rdata = 0xA5A5 at addr 3 on the next cycle.
- Debug load and peek:
  - dbg write 0x1234 to addr 5 → dbg_ack pulses 1 cycle later; cpu_rdata at addr 5 = 0x1234.
  - dbg read of addr 3 → dbg_rdata = 0xA5A5 with dbg_ack.
- Collision: cpu_we = 1 for 3 cycles while dbg_req = 1.
  - dbg_ack is delayed until the first cycle with cpu_we = 0, then pulses once.
  - Both writes land.
- Boundary: DEPTH = 6, CPU write 0xDEF0 to addr 7.
  - mem is unchanged; cpu_rdata at addr 7 = 0.
  - dbg read of addr 7 acks with dbg_rdata = 0.
- Reset mid-clear: assert RST at clear cycle 3, release.
  - ready stays low for a full DEPTH cycles.
- With DMEM_LOCK_EN: lock addr 2 via a dbg write of 0x5A5A, then CPU writes 0xFFFF to addr 2 → cpu_rdata stays 0x5A5A.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and default sizes for the debug-capable data memory.
// Optional feature macro: DMEM_LOCK_EN (per-word CPU write lock).
package dmem_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        ACK   = 2'd2
    } dmem_state_t;

    localparam int DMEM_DATA_W = 16;
    localparam int DMEM_DEPTH  = 256;

endpackage

// File: rtl/dmem_dbg_if.sv
// CPU + debug bus of the data memory. The master drives addresses, data and
// requests; the slave (dmem_dbg) returns read data, ready and the ack.
// Optional feature macro: DMEM_LOCK_EN adds the dbg_lock signal.
interface dmem_dbg_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_we;
    logic [DATA_W-1:0] cpu_rdata;
    logic              ready;
    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;
`ifdef DMEM_LOCK_EN
    logic              dbg_lock;

    modport master (
        output cpu_addr, cpu_wdata, cpu_we,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        input  cpu_rdata, ready, dbg_ack, dbg_rdata
    );
    modport slave (
        input  cpu_addr, cpu_wdata, cpu_we,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        output cpu_rdata, ready, dbg_ack, dbg_rdata
    );
`else
    modport master (
        output cpu_addr, cpu_wdata, cpu_we,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  cpu_rdata, ready, dbg_ack, dbg_rdata
    );
    modport slave (
        input  cpu_addr, cpu_wdata, cpu_we,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output cpu_rdata, ready, dbg_ack, dbg_rdata
    );
`endif
endinterface

// File: rtl/dmem_dbg_array.sv
// Word storage: one write port, two combinational read ports.
// Addresses at or beyond DEPTH read as zero and are never written.
module dmem_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [ADDR_W-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o
);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic w_ok_s;
    logic a_ok_s;
    logic b_ok_s;

    assign w_ok_s = ({1'b0, waddr_i}   < DEPTH_L);
    assign a_ok_s = ({1'b0, raddr_a_i} < DEPTH_L);
    assign b_ok_s = ({1'b0, raddr_b_i} < DEPTH_L);

    // Storage write; contents are deliberately not reset (the clear sequence zeroes them).
    always_ff @(posedge clk_i) begin
        if (we_i && w_ok_s) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = a_ok_s ? mem_q[raddr_a_i] : {DATA_W{1'b0}};
    assign rdata_b_o = b_ok_s ? mem_q[raddr_b_i] : {DATA_W{1'b0}};

endmodule

// File: rtl/dmem_dbg.sv
// Data memory with post-reset hardware clear and a debug load/peek port.
// The CPU always wins the single write port; a debug access runs only in a
// RUN cycle without a CPU write, then ACK pulses for one cycle.
// Optional feature macro: DMEM_LOCK_EN (debug-set per-word CPU write lock).
module dmem_dbg
    import dmem_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int DEPTH  = DMEM_DEPTH
) (
    input  logic       CLK,
    input  logic       RST,
    dmem_dbg_if.slave  bus
);
    localparam int              ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);

    dmem_state_t       state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              ready_q, ready_d;
    logic              ack_q, ack_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic [DATA_W-1:0] rdata_a_s;
    logic [DATA_W-1:0] rdata_b_s;
    logic              cpu_wr_ok_s;

`ifdef DMEM_LOCK_EN
    logic [DEPTH-1:0]  lock_q, lock_d;
    logic              cpu_locked_s;

    assign cpu_locked_s = ({1'b0, bus.cpu_addr} < DEPTH_L) ? lock_q[bus.cpu_addr] : 1'b0;
`else
    logic              cpu_locked_s;

    assign cpu_locked_s = 1'b0;
`endif

    assign cpu_wr_ok_s = bus.cpu_we & ~cpu_locked_s;

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk_i     (CLK),
        .we_i      (mem_we_s),
        .waddr_i   (mem_waddr_s),
        .wdata_i   (mem_wdata_s),
        .raddr_a_i (bus.cpu_addr),
        .rdata_a_o (rdata_a_s),
        .raddr_b_i (bus.dbg_addr),
        .rdata_b_o (rdata_b_s)
    );

    // Next-state, write-port arbitration and debug read capture.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        dbg_rdata_d = dbg_rdata_q;
        mem_we_s    = 1'b0;
        mem_waddr_s = bus.cpu_addr;
        mem_wdata_s = bus.cpu_wdata;
`ifdef DMEM_LOCK_EN
        lock_d      = lock_q;
`endif
        case (state_q)
            CLEAR: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = clr_cnt_q;
                mem_wdata_s = {DATA_W{1'b0}};
`ifdef DMEM_LOCK_EN
                lock_d      = {DEPTH{1'b0}};
`endif
                if (clr_cnt_q == LAST_A) begin
                    state_d   = RUN;
                    clr_cnt_d = {ADDR_W{1'b0}};
                end else begin
                    clr_cnt_d = clr_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            RUN: begin
                if (bus.cpu_we) begin
                    mem_we_s = cpu_wr_ok_s;
                end else if (bus.dbg_req) begin
                    state_d = ACK;
                    if (bus.dbg_we) begin
                        mem_we_s    = 1'b1;
                        mem_waddr_s = bus.dbg_addr;
                        mem_wdata_s = bus.dbg_wdata;
`ifdef DMEM_LOCK_EN
                        if ({1'b0, bus.dbg_addr} < DEPTH_L) begin
                            lock_d[bus.dbg_addr] = bus.dbg_lock;
                        end else begin
                            lock_d = lock_q;
                        end
`endif
                    end else begin
                        dbg_rdata_d = rdata_b_s;
                    end
                end else begin
                    mem_we_s = 1'b0;
                end
            end
            ACK: begin
                mem_we_s = cpu_wr_ok_s;
                state_d  = RUN;
            end
            default: begin
                state_d   = CLEAR;
                clr_cnt_d = {ADDR_W{1'b0}};
            end
        endcase
        ready_d = (state_d != CLEAR);
        ack_d   = (state_d == ACK);
    end

    // State, clear counter and registered status/read-data outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= {ADDR_W{1'b0}};
            ready_q     <= 1'b0;
            ack_q       <= 1'b0;
            dbg_rdata_q <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            ready_q     <= ready_d;
            ack_q       <= ack_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

`ifdef DMEM_LOCK_EN
    // Lock bits; cleared by the clear sequence rather than by reset.
    always_ff @(posedge CLK) begin
        lock_q <= lock_d;
    end
`endif

    assign bus.cpu_rdata = (state_q == CLEAR) ? {DATA_W{1'b0}} : rdata_a_s;
    assign bus.ready     = ready_q;
    assign bus.dbg_ack   = ack_q;
    assign bus.dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_dbg.sv
// Directed bench for dmem_dbg: a DEPTH=8 instance for the main checks and a
// DEPTH=6 instance for out-of-range behaviour. Lock checks run when
// DMEM_LOCK_EN is defined.
module tb_dmem_dbg;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    always #5 CLK = ~CLK;

    dmem_dbg_if #(.DATA_W(16), .ADDR_W(3)) bus8 ();
    dmem_dbg_if #(.DATA_W(16), .ADDR_W(3)) bus6 ();

    dmem_dbg #(.DATA_W(16), .DEPTH(8)) u_dut8 (.CLK(CLK), .RST(RST), .bus(bus8));
    dmem_dbg #(.DATA_W(16), .DEPTH(6)) u_dut6 (.CLK(CLK), .RST(RST), .bus(bus6));

    int n_vec = 0;
    int n_err = 0;

    // Single comparison point for every check.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One cycle: let the rising edge happen, then sample on the falling edge.
    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // CPU write on one instance (sel 0 = DEPTH 8, sel 1 = DEPTH 6).
    task automatic cpu_wr(input int sel, input logic [2:0] a, input logic [15:0] d);
        if (sel == 0) begin
            bus8.cpu_addr = a; bus8.cpu_wdata = d; bus8.cpu_we = 1'b1;
            step();
            bus8.cpu_we = 1'b0;
        end else begin
            bus6.cpu_addr = a; bus6.cpu_wdata = d; bus6.cpu_we = 1'b1;
            step();
            bus6.cpu_we = 1'b0;
        end
    endtask

    // Combinational CPU read.
    task automatic cpu_rd(input int sel, input logic [2:0] a, output logic [15:0] d);
        if (sel == 0) begin
            bus8.cpu_addr = a; #1; d = bus8.cpu_rdata;
        end else begin
            bus6.cpu_addr = a; #1; d = bus6.cpu_rdata;
        end
    endtask

    // Debug access held until ack (bounded); returns cycles waited.
    task automatic dbg_xfer(input int sel, input logic we, input logic lk, input logic [2:0] a,
                            input logic [15:0] d, output int cyc);
        logic ack;
        cyc = 0;
        if (sel == 0) begin
            bus8.dbg_req = 1'b1; bus8.dbg_we = we; bus8.dbg_addr = a; bus8.dbg_wdata = d;
`ifdef DMEM_LOCK_EN
            bus8.dbg_lock = lk;
`endif
        end else begin
            bus6.dbg_req = 1'b1; bus6.dbg_we = we; bus6.dbg_addr = a; bus6.dbg_wdata = d;
`ifdef DMEM_LOCK_EN
            bus6.dbg_lock = lk;
`endif
        end
        do begin
            step();
            cyc++;
            ack = (sel == 0) ? bus8.dbg_ack : bus6.dbg_ack;
        end while (!ack && cyc < 20);
        check_val("dbg_ack_seen", {31'd0, ack}, 32'd1);
        bus8.dbg_req = 1'b0;
        bus6.dbg_req = 1'b0;
`ifdef DMEM_LOCK_EN
        bus8.dbg_lock = 1'b0;
        bus6.dbg_lock = 1'b0;
`endif
    endtask

    logic [15:0] rd;
    int          cyc;

    initial begin
        bus8.cpu_addr = 3'd0; bus8.cpu_wdata = 16'h0000; bus8.cpu_we = 1'b0;
        bus8.dbg_req = 1'b0; bus8.dbg_we = 1'b0; bus8.dbg_addr = 3'd0; bus8.dbg_wdata = 16'h0000;
        bus6.cpu_addr = 3'd0; bus6.cpu_wdata = 16'h0000; bus6.cpu_we = 1'b0;
        bus6.dbg_req = 1'b0; bus6.dbg_we = 1'b0; bus6.dbg_addr = 3'd0; bus6.dbg_wdata = 16'h0000;
`ifdef DMEM_LOCK_EN
        bus8.dbg_lock = 1'b0;
        bus6.dbg_lock = 1'b0;
`endif
        // Reset state
        step(); step();
        check_val("rst_ready", {31'd0, bus8.ready}, 32'd0);
        check_val("rst_ack", {31'd0, bus8.dbg_ack}, 32'd0);
        check_val("rst_dbg_rdata", {16'd0, bus8.dbg_rdata}, 32'd0);

        // Clear: ready after exactly DEPTH cycles (8 and 6)
        RST = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            check_val($sformatf("clr_ready8_c%0d", i), {31'd0, bus8.ready}, (i >= 8) ? 32'd1 : 32'd0);
            check_val($sformatf("clr_ready6_c%0d", i), {31'd0, bus6.ready}, (i >= 6) ? 32'd1 : 32'd0);
        end
        for (int a = 0; a < 8; a++) begin
            cpu_rd(0, 3'(a), rd);
            check_val($sformatf("clr_rd_a%0d", a), {16'd0, rd}, 32'h0000);
        end

        // CPU write / read
        cpu_wr(0, 3'd3, 16'hA5A5);
        cpu_rd(0, 3'd3, rd);
        check_val("cpu_rd3", {16'd0, rd}, 32'hA5A5);

        // Debug write: ack one cycle later, for one cycle only
        dbg_xfer(0, 1'b1, 1'b0, 3'd5, 16'h1234, cyc);
        check_val("dbg_wr_latency", cyc, 32'd1);
        step();
        check_val("dbg_ack_one_cycle", {31'd0, bus8.dbg_ack}, 32'd0);
        cpu_rd(0, 3'd5, rd);
        check_val("dbg_wr_landed", {16'd0, rd}, 32'h1234);

        // Debug read
        dbg_xfer(0, 1'b0, 1'b0, 3'd3, 16'h0000, cyc);
        check_val("dbg_rd_latency", cyc, 32'd1);
        check_val("dbg_rd_data", {16'd0, bus8.dbg_rdata}, 32'hA5A5);
        step();
        check_val("dbg_rdata_held", {16'd0, bus8.dbg_rdata}, 32'hA5A5);

        // Collision: CPU writes for 3 cycles while a debug write waits
        bus8.cpu_addr = 3'd6; bus8.cpu_wdata = 16'h0BEE; bus8.cpu_we = 1'b1;
        bus8.dbg_req = 1'b1; bus8.dbg_we = 1'b1; bus8.dbg_addr = 3'd1; bus8.dbg_wdata = 16'h7777;
        for (int i = 1; i <= 3; i++) begin
            step();
            check_val($sformatf("coll_no_ack_c%0d", i), {31'd0, bus8.dbg_ack}, 32'd0);
        end
        bus8.cpu_we = 1'b0;
        step();
        check_val("coll_ack", {31'd0, bus8.dbg_ack}, 32'd1);
        bus8.dbg_req = 1'b0;
        step();
        check_val("coll_ack_once", {31'd0, bus8.dbg_ack}, 32'd0);
        cpu_rd(0, 3'd6, rd);
        check_val("coll_cpu_landed", {16'd0, rd}, 32'h0BEE);
        cpu_rd(0, 3'd1, rd);
        check_val("coll_dbg_landed", {16'd0, rd}, 32'h7777);

        // Boundary on DEPTH 6: out-of-range write dropped, reads give 0
        cpu_wr(1, 3'd7, 16'hDEF0);
        cpu_rd(1, 3'd7, rd);
        check_val("oor_cpu_rd7", {16'd0, rd}, 32'h0000);
        for (int a = 0; a < 6; a++) begin
            cpu_rd(1, 3'(a), rd);
            check_val($sformatf("oor_unchanged_a%0d", a), {16'd0, rd}, 32'h0000);
        end
        cpu_wr(1, 3'd4, 16'h4444);
        dbg_xfer(1, 1'b0, 1'b0, 3'd4, 16'h0000, cyc);
        check_val("oor_pre_rd4", {16'd0, bus6.dbg_rdata}, 32'h4444);
        step();
        dbg_xfer(1, 1'b0, 1'b0, 3'd7, 16'h0000, cyc);
        check_val("oor_dbg_rd7", {16'd0, bus6.dbg_rdata}, 32'h0000);
        step();
        dbg_xfer(1, 1'b1, 1'b0, 3'd6, 16'hBEEF, cyc);
        step();
        cpu_rd(1, 3'd0, rd);
        check_val("oor_dbg_wr_dropped", {16'd0, rd}, 32'h0000);

        // Reset mid-clear: restart and take a full DEPTH cycles again
        RST = 1'b0;
        step();
        RST = 1'b1;
        step(); step(); step();
        check_val("midclr_ready_c3", {31'd0, bus8.ready}, 32'd0);
        RST = 1'b0;
        step();
        check_val("midclr_rst_ready", {31'd0, bus8.ready}, 32'd0);
        RST = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            check_val($sformatf("reclr_ready8_c%0d", i), {31'd0, bus8.ready}, (i >= 8) ? 32'd1 : 32'd0);
        end
        cpu_rd(0, 3'd3, rd);
        check_val("reclr_a3_zero", {16'd0, rd}, 32'h0000);
        cpu_rd(0, 3'd7, rd);
        check_val("reclr_a7_zero", {16'd0, rd}, 32'h0000);

`ifdef DMEM_LOCK_EN
        // Lock: debug write with lock blocks CPU writes until unlocked
        dbg_xfer(0, 1'b1, 1'b1, 3'd2, 16'h5A5A, cyc);
        step();
        cpu_wr(0, 3'd2, 16'hFFFF);
        cpu_rd(0, 3'd2, rd);
        check_val("lock_blocks_cpu", {16'd0, rd}, 32'h5A5A);
        cpu_wr(0, 3'd3, 16'hFFFF);
        cpu_rd(0, 3'd3, rd);
        check_val("lock_other_word", {16'd0, rd}, 32'hFFFF);
        dbg_xfer(0, 1'b1, 1'b0, 3'd2, 16'h1010, cyc);
        step();
        cpu_wr(0, 3'd2, 16'hFFFF);
        cpu_rd(0, 3'd2, rd);
        check_val("unlock_cpu_wr", {16'd0, rd}, 32'hFFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
